// File: rtl/alu16_pkg.sv
// Shared ALU16 definitions: counter FSM state encoding, default width and
// iteration counts used by the multiply/divide sequencer.
package alu16_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      COUNT = 2'b01,
      TERM  = 2'b10
   } state_e;

   localparam int CNT_W    = 4;
   localparam int MUL_ITER = 8;
   localparam int DIV_ITER = 8;

endpackage

// File: rtl/down_counter_if.sv
// Control/status bundle between the ALU16 sequencer (master) and the
// loadable down-counter (slave).
interface down_counter_if #(
   parameter int WIDTH = alu16_pkg::CNT_W
);

   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             c_down;
   logic [WIDTH-1:0] out;
   logic             busy;
   logic             done;
   logic             underflow;

   modport master (
      output load, load_val, c_down,
      input  out, busy, done, underflow
   );

   modport slave (
      input  load, load_val, c_down,
      output out, busy, done, underflow
   );

endinterface

// File: rtl/ffd_sr.sv
// Single-bit D flop with enable and synchronous active-high reset;
// reset takes priority over enable.
module ffd_sr (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic d_i,
   output logic q_o
);

   always_ff @(posedge clk) begin
      if (rst)
         q_o <= 1'b0;
      else if (en_i)
         q_o <= d_i;
   end

endmodule

// File: rtl/down_counter.sv
// Loadable down-counter with busy flag, terminal-count pulse and sticky underflow.
// Define DOWN_COUNTER_WRAP_EN to wrap 0 -> 2^WIDTH-1 on decrement instead of saturating.
module down_counter
   import alu16_pkg::*;
#(
   parameter int WIDTH = CNT_W
) (
   input  logic           clk,
   input  logic           rst,
   down_counter_if.slave  bus
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [1:0]       state_bits_q;
   state_e           state_q, state_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             uf_q, uf_d;
   logic             cnt_en;

   assign state_q = state_e'(state_bits_q);
   assign cnt_en  = bus.load | bus.c_down;

   always_comb begin
      cnt_d   = cnt_q;
      state_d = state_q;
      done_d  = 1'b0;
      uf_d    = uf_q;
      if (bus.load) begin
         cnt_d = bus.load_val;
         uf_d  = 1'b0;
         if (bus.load_val != '0) begin
            state_d = COUNT;
         end else begin
            state_d = TERM;
            done_d  = 1'b1;
         end
      end else if (bus.c_down) begin
         if (cnt_q == '0) begin
            uf_d = 1'b1;
`ifdef DOWN_COUNTER_WRAP_EN
            cnt_d   = '1;
            state_d = COUNT;
`endif
         end else begin
            cnt_d = cnt_q - ONE;
            if (cnt_q == ONE) begin
               state_d = TERM;
               done_d  = 1'b1;
            end
         end
      end
   end

   // busy is the registered image of the next state being COUNT
   assign busy_d = (state_d == COUNT);

   for (genvar i = 0; i < WIDTH; i++) begin : g_cnt
      ffd_sr u_cnt (
         .clk  (clk),
         .rst  (rst),
         .en_i (cnt_en),
         .d_i  (cnt_d[i]),
         .q_o  (cnt_q[i])
      );
   end

   for (genvar i = 0; i < 2; i++) begin : g_state
      ffd_sr u_state (
         .clk  (clk),
         .rst  (rst),
         .en_i (1'b1),
         .d_i  (state_d[i]),
         .q_o  (state_bits_q[i])
      );
   end

   ffd_sr u_busy (
      .clk  (clk),
      .rst  (rst),
      .en_i (1'b1),
      .d_i  (busy_d),
      .q_o  (busy_q)
   );

   ffd_sr u_done (
      .clk  (clk),
      .rst  (rst),
      .en_i (1'b1),
      .d_i  (done_d),
      .q_o  (done_q)
   );

   ffd_sr u_uf (
      .clk  (clk),
      .rst  (rst),
      .en_i (1'b1),
      .d_i  (uf_d),
      .q_o  (uf_q)
   );

   assign bus.out       = cnt_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.underflow = uf_q;

endmodule

// File: tb/tb_down_counter.sv
// Directed bench for down_counter (WIDTH=4); expectations follow DOWN_COUNTER_WRAP_EN.
module tb_down_counter;

   localparam int W = 4;
`ifdef DOWN_COUNTER_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   down_counter_if #(.WIDTH(W)) bus ();

   down_counter #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int e_out, input bit e_busy,
                          input bit e_done, input bit e_uf);
      chk({tag, ".out"},  32'(bus.out),       32'(e_out));
      chk({tag, ".busy"}, 32'(bus.busy),      32'(e_busy));
      chk({tag, ".done"}, 32'(bus.done),      32'(e_done));
      chk({tag, ".uf"},   32'(bus.underflow), 32'(e_uf));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_tests      = 0;
      n_fail       = 0;
      rst          = 1'b1;
      bus.load     = 1'b1;
      bus.load_val = 4'd5;
      bus.c_down   = 1'b0;

      // reset dominates a pending load
      step(); chk_all("rst0", 0, 0, 0, 0);
      step(); chk_all("rst1", 0, 0, 0, 0);

      // decrement in IDLE: underflow, wrap or saturate
      rst = 1'b0; bus.load = 1'b0; bus.c_down = 1'b1;
      step(); chk_all("idle_dec", WRAP ? 15 : 0, WRAP, 0, 1);

      // load 3 and count down
      bus.load = 1'b1; bus.load_val = 4'd3; bus.c_down = 1'b0;
      step(); chk_all("ld3", 3, 1, 0, 0);
      bus.load = 1'b0; bus.c_down = 1'b1;
      step(); chk_all("dec2", 2, 1, 0, 0);
      step(); chk_all("dec1", 1, 1, 0, 0);
      step(); chk_all("dec0", 0, 0, 1, 0);
      bus.c_down = 1'b0;
      step(); chk_all("term_hold", 0, 0, 0, 0);

      // load 0: single done pulse, no busy
      bus.load = 1'b1; bus.load_val = 4'd0;
      step(); chk_all("ld0", 0, 0, 1, 0);
      bus.load = 1'b0;
      step(); chk_all("ld0_after", 0, 0, 0, 0);

      // decrement in TERM
      bus.c_down = 1'b1;
      step(); chk_all("term_dec", WRAP ? 15 : 0, WRAP, 0, 1);
      bus.c_down = 1'b0;
      step(); chk_all("term_dec_hold", WRAP ? 15 : 0, WRAP, 0, 1);

      // load 4 with simultaneous c_down: decrement ignored, underflow cleared
      bus.load = 1'b1; bus.load_val = 4'd4; bus.c_down = 1'b1;
      step(); chk_all("ld4_dec", 4, 1, 0, 0);
      bus.load = 1'b0;
      step(); chk_all("dec3", 3, 1, 0, 0);
      step(); chk_all("dec2b", 2, 1, 0, 0);
      bus.load = 1'b1; bus.load_val = 4'd9; bus.c_down = 1'b0;
      step(); chk_all("ld9", 9, 1, 0, 0);
      bus.load = 1'b0;
      step(); chk_all("hold9", 9, 1, 0, 0);

      // reset mid-count at 6: no done pulse
      bus.load = 1'b1; bus.load_val = 4'd6;
      step(); chk_all("ld6", 6, 1, 0, 0);
      bus.load = 1'b0; bus.c_down = 1'b1; rst = 1'b1;
      step(); chk_all("rst_mid", 0, 0, 0, 0);
      rst = 1'b0; bus.c_down = 1'b0;
      step(); chk_all("rst_after", 0, 0, 0, 0);

      // normal operation after reset
      bus.load = 1'b1; bus.load_val = 4'd2;
      step(); chk_all("ld2", 2, 1, 0, 0);
      bus.load = 1'b0; bus.c_down = 1'b1;
      step(); chk_all("ld2_dec1", 1, 1, 0, 0);
      step(); chk_all("ld2_dec0", 0, 0, 1, 0);
      bus.c_down = 1'b0;
      step(); chk_all("ld2_term", 0, 0, 0, 0);

      // load maximum value and single decrement
      bus.load = 1'b1; bus.load_val = 4'd15;
      step(); chk_all("ld15", 15, 1, 0, 0);
      bus.load = 1'b0; bus.c_down = 1'b1;
      step(); chk_all("dec14", 14, 1, 0, 0);
      bus.c_down = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
